// File: rtl/dehaze_frame_if.sv
// Dark-channel pixel stream into the per-frame dehaze controller.
// The stream source drives all four signals; the controller only observes them.
interface dehaze_frame_if;
    logic [7:0] dark;
    logic       hsync;
    logic       vsync;
    logic       de;

    modport master (output dark, hsync, vsync, de);
    modport slave  (input  dark, hsync, vsync, de);
endinterface

// File: rtl/dehaze_frame_ctrl.sv
// Per-frame controller for the dehaze dark-channel stage: checks frame geometry, tracks
// the peak dark value and updates the atmospheric-light estimate once per frame.
module dehaze_frame_ctrl #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int A_DEFAULT    = 255,
    parameter int SMOOTH_SHIFT = 2,
    parameter int VS_POL       = 1
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    dehaze_frame_if.slave px,
    output logic [7:0]    o_atmos,
    output logic          o_atmos_valid,
    output logic          o_frame_done,
    output logic          o_frame_bad,
    output logic [15:0]   o_frame_cnt,
    output logic          o_dehaze_en,
    output logic [1:0]    dbg_state,
    output logic          dbg_hsync
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    localparam logic [11:0] H_CMP  = 12'(H_ACTIVE);
    localparam logic [10:0] V_CMP  = 11'(V_ACTIVE);
    localparam logic        VS_ACT = (VS_POL != 0);

    state_t             state_q, state_d;
    logic               vs_prev_q, de_prev_q;
    logic [11:0]        pix_cnt_q;
    logic [10:0]        line_cnt_q;
    logic               line_err_q;
    logic [7:0]         max_q;
    logic [10:0]        snap_lines_q;
    logic               snap_err_q;
    logic [7:0]         snap_max_q;
    logic [15:0]        frame_cnt_q;
    logic               vs_act, frame_edge, de_fall, frame_good;
    logic signed [8:0]  diff, step;
    logic [7:0]         a_next;

    assign vs_act     = (px.vsync == VS_ACT);
    assign frame_edge = vs_act && !vs_prev_q;
    assign de_fall    = de_prev_q && !px.de;
    assign frame_good = (snap_lines_q == V_CMP) && !snap_err_q;

    // IIR step toward the new frame max; arithmetic shift rounds toward minus infinity.
    assign diff   = $signed({1'b0, snap_max_q}) - $signed({1'b0, o_atmos});
    assign step   = diff >>> SMOOTH_SHIFT;
    assign a_next = o_atmos + step[7:0];

    assign o_frame_cnt = frame_cnt_q;
    assign dbg_state   = state_q;
    assign dbg_hsync   = px.hsync;

    always_ff @(posedge pixelclk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_edge) state_d = S_FRAME;
            S_FRAME:  if (frame_edge) state_d = S_UPDATE;
            S_UPDATE: state_d = S_FRAME;
            default:  state_d = S_IDLE;
        endcase
    end

    // Live geometry/peak tracking; a frame edge restarts it, counting a pixel in that cycle.
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            line_err_q <= 1'b0;
            max_q      <= '0;
        end else begin
            vs_prev_q <= vs_act;
            de_prev_q <= px.de;
            if (frame_edge) begin
                pix_cnt_q  <= px.de ? 12'd1 : 12'd0;
                line_cnt_q <= '0;
                line_err_q <= 1'b0;
                max_q      <= px.de ? px.dark : 8'd0;
            end else begin
                if (px.de && pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + 12'd1;
                if (px.de && px.dark > max_q) max_q <= px.dark;
                if (de_fall) begin
                    if (line_cnt_q != '1)  line_cnt_q <= line_cnt_q + 11'd1;
                    if (pix_cnt_q != H_CMP) line_err_q <= 1'b1;
                    pix_cnt_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            snap_lines_q <= '0;
            snap_err_q   <= 1'b0;
            snap_max_q   <= '0;
        end else if (frame_edge && state_q == S_FRAME) begin
            snap_lines_q <= line_cnt_q;
            snap_err_q   <= line_err_q;
            snap_max_q   <= max_q;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            o_atmos       <= 8'(A_DEFAULT);
            o_atmos_valid <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_bad   <= 1'b0;
            frame_cnt_q   <= '0;
            o_dehaze_en   <= 1'b0;
        end else begin
            o_frame_done <= (state_q == S_UPDATE);
            o_frame_bad  <= (state_q == S_UPDATE) && !frame_good;
            if (state_q == S_UPDATE && frame_good) begin
                o_atmos       <= o_atmos_valid ? a_next : snap_max_q;
                o_atmos_valid <= 1'b1;
                frame_cnt_q   <= frame_cnt_q + 16'd1;
                o_dehaze_en   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dehaze_frame_ctrl.sv
// Directed frame sequence with random pixel data against a frame-level model of the
// atmospheric-light controller.
module tb_dehaze_frame_ctrl;
  localparam int H  = 16;
  localparam int V  = 6;
  localparam int SH = 2;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  o_atmos;
  logic        o_atmos_valid, o_frame_done, o_frame_bad, o_dehaze_en, dbg_hsync;
  logic [15:0] o_frame_cnt;
  logic [1:0]  dbg_state;

  dehaze_frame_if px ();

  dehaze_frame_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .A_DEFAULT(255), .SMOOTH_SHIFT(SH), .VS_POL(1)
  ) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .px(px.slave),
    .o_atmos(o_atmos), .o_atmos_valid(o_atmos_valid), .o_frame_done(o_frame_done),
    .o_frame_bad(o_frame_bad), .o_frame_cnt(o_frame_cnt), .o_dehaze_en(o_dehaze_en),
    .dbg_state(dbg_state), .dbg_hsync(dbg_hsync)
  );

  always #5 pixelclk = ~pixelclk;

  int tests_run    = 0;
  int tests_failed = 0;

  // frame-level reference model
  int m_a     = 255;
  int m_cnt   = 0;
  bit m_valid = 0;
  bit m_en    = 0;
  bit m_armed = 0;
  int fr_lines = 0;
  int fr_max   = 0;
  bit fr_err   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pixelclk);
  endtask

  function automatic int floor_shift(input int d, input int k);
    if (d >= 0) return d / (1 << k);
    return -((-d + (1 << k) - 1) / (1 << k));
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_atmos"}, 32'(o_atmos), 32'(m_a));
    check({tag, "_valid"}, 32'(o_atmos_valid), 32'(m_valid));
    check({tag, "_cnt"},   32'(o_frame_cnt), 32'(m_cnt));
    check({tag, "_en"},    32'(o_dehaze_en), 32'(m_en));
  endtask

  task automatic drive_line(input int npix, input int fill);
    for (int i = 0; i < npix; i++) begin
      px.de    = 1'b1;
      px.hsync = 1'b0;
      px.dark  = (fill < 0) ? 8'($urandom_range(0, 255)) : 8'(fill);
      if (int'(px.dark) > fr_max) fr_max = int'(px.dark);
      tick();
    end
    px.de   = 1'b0;
    px.dark = 8'd0;
    fr_lines++;
    if (npix != H) fr_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      px.hsync = (i == 0);
      tick();
    end
    px.hsync = 1'b0;
  endtask

  task automatic drive_frame(input int nlines, input int odd_line, input int odd_len,
                             input int fill);
    for (int l = 0; l < nlines; l++)
      drive_line((l == odd_line) ? odd_len : H, fill);
  endtask

  task automatic frame_edge(input string tag);
    bit exp_done, exp_bad, good;
    good     = (fr_lines == V) && !fr_err;
    exp_done = m_armed;
    exp_bad  = m_armed && !good;
    if (m_armed && good) begin
      if (!m_valid) m_a = fr_max;
      else          m_a = m_a + floor_shift(fr_max - m_a, SH);
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % 65536;
      m_en    = 1'b1;
    end
    m_armed  = 1'b1;
    fr_lines = 0;
    fr_max   = 0;
    fr_err   = 1'b0;
    px.vsync = 1'b1;
    tick();
    tick();
    check({tag, "_done"}, 32'(o_frame_done), 32'(exp_done));
    check({tag, "_bad"},  32'(o_frame_bad),  32'(exp_bad));
    check_outputs(tag);
    px.vsync = 1'b0;
    tick();
    check({tag, "_done_end"}, 32'(o_frame_done), 32'd0);
    check({tag, "_bad_end"},  32'(o_frame_bad),  32'd0);
    tick();
  endtask

  task automatic model_reset();
    m_a = 255; m_cnt = 0; m_valid = 0; m_en = 0; m_armed = 0;
    fr_lines = 0; fr_max = 0; fr_err = 0;
  endtask

  initial begin
    px.dark = 8'd0; px.hsync = 1'b0; px.vsync = 1'b0; px.de = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_bad", 32'(o_frame_bad), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check_outputs("rst");

    // partial frame after reset is discarded; first edge only arms the controller
    drive_frame(2, -1, 0, -1);
    frame_edge("edge1");
    drive_frame(V, -1, 0, 100);
    frame_edge("first_good");
    check("first_a100", 32'(o_atmos), 32'd100);

    drive_frame(V, -1, 0, 200);
    frame_edge("smooth_up");
    check("smooth_a125", 32'(o_atmos), 32'd125);
    drive_frame(V, -1, 0, 0);
    frame_edge("smooth_down");
    check("smooth_a93", 32'(o_atmos), 32'd93);

    drive_frame(V, 2, H - 1, -1);
    frame_edge("short_line");
    drive_frame(V - 1, -1, 0, -1);
    frame_edge("few_lines");
    drive_frame(V + 1, -1, 0, -1);
    frame_edge("many_lines");
    drive_frame(V, 0, H + 1, -1);
    frame_edge("long_line");
    for (int f = 0; f < 4; f++) begin
      drive_frame(V, -1, 0, -1);
      frame_edge("rand_good");
    end

    // reset mid-frame: next edge re-arms, the frame after it is treated as first
    drive_frame(2, -1, 0, -1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    check("midrst_state", 32'(dbg_state), 32'd0);
    check_outputs("midrst");
    drive_frame(2, -1, 0, -1);
    frame_edge("midrst_edge");
    drive_frame(V, -1, 0, -1);
    frame_edge("midrst_first");

    // frame counter wrap
    drive_frame(1, -1, 0, -1);
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    m_cnt = 65535;
    drive_frame(V - 1, -1, 0, -1);
    frame_edge("wrap");
    check("wrap_cnt0", 32'(o_frame_cnt), 32'd0);
    check("wrap_en", 32'(o_dehaze_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
